// File: rtl/mold_message_splitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mold_message_splitter_if
//  Description : Bundles the packet-beat input channel and the ITCH message
//                byte output channel of the MoldUDP64 message splitter.
//                  dataIn/dataValid/dataReady/dataLast/lastBytes - beat channel
//                  counter      - beat index within the packet
//                  messageCount - decoded MoldUDP64 message count
//                  msgValid/msgReady/msgData/msgFirst/msgLast - byte stream
//                  truncErr     - packet ended inside a message block
//                Modport slave is the splitter's view; master is the view of
//                the surrounding environment (decoder upstream, parser
//                downstream).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mold_message_splitter_if #(
    parameter int CNT_W = 8
);
    logic [63:0]      dataIn;
    logic             dataValid;
    logic             dataReady;
    logic             dataLast;
    logic [2:0]       lastBytes;
    logic [CNT_W-1:0] counter;
    logic [15:0]      messageCount;

    logic             msgValid;
    logic             msgReady;
    logic [7:0]       msgData;
    logic             msgFirst;
    logic             msgLast;
    logic             truncErr;

    modport slave (
        input  dataIn, dataValid, dataLast, lastBytes, counter, messageCount,
        input  msgReady,
        output dataReady,
        output msgValid, msgData, msgFirst, msgLast, truncErr
    );

    modport master (
        output dataIn, dataValid, dataLast, lastBytes, counter, messageCount,
        output msgReady,
        input  dataReady,
        input  msgValid, msgData, msgFirst, msgLast, truncErr
    );
endinterface
`default_nettype wire

// File: rtl/mold_message_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : mold_message_splitter
//  Description : Walks the MoldUDP64 message blocks (2-byte big-endian length
//                followed by the body) that follow the packet header and
//                emits every ITCH message as a byte stream with first/last
//                framing. Narrows 8 bytes/beat to 1 byte/cycle and therefore
//                backpressures the beat channel.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - slave side of mold_message_splitter_if (beat channel
//                       in, message byte stream out, truncErr pulse)
//  Parameters  : PAYLOAD_START - beat index of the first payload beat
//                CNT_W         - width of the beat index
//  Revision    : 1.0 - initial release
// ============================================================================
module mold_message_splitter #(
    parameter int PAYLOAD_START = 8,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mold_message_splitter_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_PSTART    = CNT_W'(PAYLOAD_START);
    localparam logic [15:0]      c_MC_HBEAT  = 16'h0000;
    localparam logic [15:0]      c_MC_EOS    = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_BODY   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_hold_data;
    logic [3:0]  r_hold_cnt;     // valid bytes in the held beat, 1..8
    logic        r_hold_last;    // held beat is the packet's last beat
    logic        r_hold_valid;
    logic [2:0]  r_ptr;          // next byte of the held beat to process

    logic [15:0] r_msgs_left;
    logic [7:0]  r_len_hi;
    logic [15:0] r_remain;       // body bytes still owed for this message
    logic        r_first;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_len;
    logic        w_final_byte;
    logic        w_msg_valid;
    logic        w_consume;
    logic        w_hold_done;
    logic        w_pkt_done;
    logic        w_data_ready;
    logic        w_accept;
    logic        w_load;
    logic        w_first_payload;
    logic        w_msgs_dec;
    logic        w_trunc;
    logic [3:0]  w_beat_cnt;

    always_comb begin
        w_byte       = r_hold_data[{r_ptr, 3'b000} +: 8];
        w_len        = {r_len_hi, w_byte};
        w_final_byte = r_hold_valid && ({1'b0, r_ptr} == (r_hold_cnt - 4'd1));
        // msgValid depends on registers only, never on msgReady.
        w_msg_valid  = (r_state == ST_BODY) && r_hold_valid;

        w_consume = 1'b0;
        case (r_state)
            ST_LEN_HI: w_consume = r_hold_valid && (r_msgs_left != 16'd0);
            ST_LEN_LO: w_consume = r_hold_valid;
            ST_DRAIN:  w_consume = r_hold_valid;
            ST_BODY:   w_consume = w_msg_valid && bus.msgReady;
            default:   w_consume = 1'b0;
        endcase

        w_hold_done = w_consume && w_final_byte;
        w_pkt_done  = w_hold_done && r_hold_last;

        // Reload in the same cycle the last held byte leaves: no bubble.
        w_data_ready    = !rst && (!r_hold_valid || w_hold_done);
        w_accept        = bus.dataValid && w_data_ready;
        w_load          = w_accept && (bus.counter >= c_PSTART);
        w_first_payload = w_load && (bus.counter == c_PSTART);

        w_beat_cnt = 4'd8;
        if (bus.dataLast && (bus.lastBytes != 3'd0)) begin
            w_beat_cnt = {1'b0, bus.lastBytes};
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_msgs_dec  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (r_msgs_left == 16'd0) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_consume) begin
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_consume) begin
                    if (w_len == 16'd0) begin
                        w_msgs_dec  = 1'b1;
                        w_state_nxt = ST_LEN_HI;
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (w_consume && (r_remain == 16'd1)) begin
                    w_msgs_dec  = 1'b1;
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DRAIN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // End of packet overrides everything; a payload beat loading in the
        // same cycle starts the next walk straight away.
        if (w_pkt_done) begin
            w_state_nxt = w_load ? ST_LEN_HI : ST_IDLE;
        end

        // Packet ended inside a block: after the high length byte, after a
        // non-zero length, or with body bytes still owed.
        w_trunc = w_pkt_done &&
                  ((r_state == ST_LEN_HI) ||
                   ((r_state == ST_LEN_LO) && (w_len != 16'd0)) ||
                   ((r_state == ST_BODY) && (r_remain > 16'd1)));
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Hold register and block-walk datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_data  <= 64'd0;
            r_hold_cnt   <= 4'd0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_ptr        <= 3'd0;
            r_msgs_left  <= 16'd0;
            r_len_hi     <= 8'd0;
            r_remain     <= 16'd0;
            r_first      <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold_data  <= bus.dataIn;
                r_hold_cnt   <= w_beat_cnt;
                r_hold_last  <= bus.dataLast;
                r_hold_valid <= 1'b1;
                r_ptr        <= 3'd0;
            end else if (w_hold_done) begin
                r_hold_valid <= 1'b0;
            end else if (w_consume) begin
                r_ptr <= r_ptr + 3'd1;
            end

            if ((r_state == ST_LEN_HI) && w_consume) begin
                r_len_hi <= w_byte;
            end

            if ((r_state == ST_LEN_LO) && w_consume) begin
                r_remain <= w_len;
                r_first  <= 1'b1;
            end

            if ((r_state == ST_BODY) && w_consume) begin
                r_remain <= r_remain - 16'd1;
                r_first  <= 1'b0;
            end

            // Heartbeat and end-of-session carry no message blocks.
            if (w_first_payload) begin
                if ((bus.messageCount == c_MC_HBEAT) || (bus.messageCount == c_MC_EOS)) begin
                    r_msgs_left <= 16'd0;
                end else begin
                    r_msgs_left <= bus.messageCount;
                end
            end else if (w_pkt_done) begin
                r_msgs_left <= 16'd0;
            end else if (w_msgs_dec) begin
                r_msgs_left <= r_msgs_left - 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.dataReady = w_data_ready;
    assign bus.msgValid  = w_msg_valid;
    assign bus.msgData   = w_msg_valid ? w_byte : 8'h00;
    assign bus.msgFirst  = w_msg_valid && r_first;
    // A truncated message still gets a closing byte on the packet's end.
    assign bus.msgLast   = w_msg_valid &&
                           ((r_remain == 16'd1) || (r_hold_last && w_final_byte));
    assign bus.truncErr  = w_trunc;

endmodule
`default_nettype wire

// File: tb/tb_mold_message_splitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mold_message_splitter
//  Description : Self-checking bench for mold_message_splitter. Payloads are
//                parsed by a block-level reference model into an expected
//                byte queue that a monitor compares against the DUT output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mold_message_splitter;

    localparam int c_PAYLOAD_START = 8;
    localparam int c_CNT_W         = 8;

    typedef logic [7:0] byte_q_t[$];

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic       trunc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mold_message_splitter_if #(.CNT_W(c_CNT_W)) bif ();

    mold_message_splitter #(
        .PAYLOAD_START (c_PAYLOAD_START),
        .CNT_W         (c_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    exp_t exp_q[$];
    int   vec_cnt    = 0;
    int   err_cnt    = 0;
    int   trunc_seen = 0;
    int   trunc_exp  = 0;
    bit   mon_en     = 1'b0;
    bit   gap_en     = 1'b0;
    int   rdy_mode   = 0;    // 0: always ready, 1: random, 2: toggle

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: walk length-prefixed blocks of the payload.
    task automatic model_packet(input byte_q_t pl, input logic [15:0] mc);
        int   n, i, sz, len, avail, k;
        exp_t e;
        n = ((mc == 16'h0000) || (mc == 16'hFFFF)) ? 0 : int'(mc);
        i = 0;
        sz = pl.size();
        trunc_exp = 0;
        while ((n > 0) && (i < sz)) begin
            if (i + 2 > sz) begin
                trunc_exp++;
                break;
            end
            len = int'({pl[i], pl[i+1]});
            i += 2;
            if (len == 0) begin
                n--;
                continue;
            end
            avail = sz - i;
            if (avail == 0) begin
                trunc_exp++;
                break;
            end
            k = (len < avail) ? len : avail;
            for (int j = 0; j < k; j++) begin
                e.data  = pl[i+j];
                e.first = (j == 0);
                e.last  = (j == k - 1);
                e.trunc = (j == k - 1) && (len > avail);
                exp_q.push_back(e);
            end
            if (len > avail) trunc_exp++;
            i += k;
            n--;
        end
    endtask

    // Downstream ready pattern
    initial begin
        bif.msgReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bif.msgReady = ($urandom_range(0, 3) != 0);
                2:       bif.msgReady = ~bif.msgReady;
                default: bif.msgReady = 1'b1;
            endcase
        end
    end

    // Output monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (bif.truncErr) trunc_seen++;
                if (bif.msgValid && bif.msgReady) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_byte", {31'd0, bif.msgValid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("msg_data",  {24'd0, bif.msgData},  {24'd0, e.data});
                        check_eq("msg_first", {31'd0, bif.msgFirst}, {31'd0, e.first});
                        check_eq("msg_last",  {31'd0, bif.msgLast},  {31'd0, e.last});
                        check_eq("trunc_err", {31'd0, bif.truncErr}, {31'd0, e.trunc});
                    end
                end
            end
        end
    end

    // Starts and ends at posedge + 1.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] cnt,
                             input logic last, input logic [2:0] lb);
        logic r;
        int   guard;
        bif.dataIn    = d;
        bif.counter   = cnt;
        bif.dataLast  = last;
        bif.lastBytes = lb;
        bif.dataValid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            r = bif.dataReady;
            @(posedge clk);
            if (r) break;
            guard++;
            if (guard > 3000) begin
                check_eq("beat_accept_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        #1;
        bif.dataValid = 1'b0;
        bif.dataLast  = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = gap_en ? $urandom_range(0, 2) : 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input byte_q_t pl, input logic [15:0] mc);
        int          nb, rem;
        logic [63:0] d;
        bif.messageCount = mc;
        for (int h = 0; h < c_PAYLOAD_START; h++) begin
            send_beat({$urandom, $urandom}, 8'(h), 1'b0, 3'd0);
            gap();
        end
        nb = (pl.size() + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < pl.size()) d[8*k +: 8] = pl[b*8+k];
            end
            rem = pl.size() - b * 8;
            send_beat(d, 8'(c_PAYLOAD_START + b), (b == nb - 1), (rem >= 8) ? 3'd0 : 3'(rem));
            if (b != nb - 1) gap();
        end
    endtask

    task automatic finish_packet(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0) && (guard < 4000)) begin
            @(posedge clk);
            guard++;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (12) @(posedge clk);
        #1;
        check_eq({tag, "_trunc_count"}, 32'(trunc_seen), 32'(trunc_exp));
        check_eq({tag, "_idle_ready"}, {31'd0, bif.dataReady}, 32'd1);
    endtask

    task automatic run_packet(input byte_q_t pl, input logic [15:0] mc, input string tag);
        trunc_seen = 0;
        model_packet(pl, mc);
        send_packet(pl, mc);
        finish_packet(tag);
    endtask

    task automatic rand_packet();
        byte_q_t     pl;
        int          nm, len, sel, cut;
        logic [15:0] mc;
        pl = {};
        nm = $urandom_range(1, 4);
        for (int m = 0; m < nm; m++) begin
            len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 14);
            pl.push_back(8'(len >> 8));
            pl.push_back(8'(len));
            for (int j = 0; j < len; j++) pl.push_back(8'($urandom));
        end
        sel = $urandom_range(0, 9);
        mc  = 16'(nm);
        if (sel == 0)                 mc = 16'h0000;
        else if (sel == 1)            mc = 16'hFFFF;
        else if ((sel == 2) && (nm > 1)) mc = 16'(nm - 1);
        else if (sel == 3)            mc = 16'(nm + 1);
        if (sel == 4) begin
            repeat ($urandom_range(1, 5)) pl.push_back(8'($urandom));
        end
        if (((sel == 5) || (sel == 6)) && (pl.size() > 1)) begin
            cut = $urandom_range(1, pl.size() - 1);
            pl = pl[0:cut-1];
        end
        run_packet(pl, mc, "rand");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t pl;

        rst              = 1'b1;
        bif.dataIn       = 64'd0;
        bif.dataValid    = 1'b0;
        bif.dataLast     = 1'b0;
        bif.lastBytes    = 3'd0;
        bif.counter      = '0;
        bif.messageCount = 16'd0;

        // ---------------- reset state ----------------
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_data_ready", {31'd0, bif.dataReady}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_data_ready_after", {31'd0, bif.dataReady}, 32'd1);
        check_eq("rst_msg_valid", {31'd0, bif.msgValid}, 32'd0);
        check_eq("rst_msg_data",  {24'd0, bif.msgData},  32'd0);
        check_eq("rst_msg_first", {31'd0, bif.msgFirst}, 32'd0);
        check_eq("rst_msg_last",  {31'd0, bif.msgLast},  32'd0);
        check_eq("rst_trunc",     {31'd0, bif.truncErr}, 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // ---------------- single message with latency ----------------
        pl = {};
        pl.push_back(8'h00); pl.push_back(8'h03);
        pl.push_back(8'h41); pl.push_back(8'h42); pl.push_back(8'h43);
        trunc_seen = 0;
        model_packet(pl, 16'd1);
        send_packet(pl, 16'd1);
        @(negedge clk);  // t+1
        check_eq("single_t1_valid", {31'd0, bif.msgValid},  32'd0);
        check_eq("single_t1_ready", {31'd0, bif.dataReady}, 32'd0);
        @(negedge clk);  // t+2
        check_eq("single_t2_valid", {31'd0, bif.msgValid},  32'd0);
        @(negedge clk);  // t+3
        check_eq("single_t3_valid", {31'd0, bif.msgValid},  32'd1);
        check_eq("single_t3_data",  {24'd0, bif.msgData},   32'h41);
        check_eq("single_t3_ready", {31'd0, bif.dataReady}, 32'd0);
        @(negedge clk);  // t+4
        check_eq("single_t4_data",  {24'd0, bif.msgData},   32'h42);
        @(negedge clk);  // t+5
        check_eq("single_t5_data",  {24'd0, bif.msgData},   32'h43);
        check_eq("single_t5_last",  {31'd0, bif.msgLast},   32'd1);
        check_eq("single_t5_ready", {31'd0, bif.dataReady}, 32'd1);
        @(negedge clk);  // t+6
        check_eq("single_t6_valid", {31'd0, bif.msgValid},  32'd0);
        finish_packet("single");

        // ---------------- two messages straddling beats, stalls ----------------
        gap_en   = 1'b1;
        rdy_mode = 2;
        pl = {};
        pl.push_back(8'h00); pl.push_back(8'h06);
        for (int j = 0; j < 6; j++) pl.push_back(8'hA0 + 8'(j));
        pl.push_back(8'h00); pl.push_back(8'h07);
        for (int j = 0; j < 7; j++) pl.push_back(8'hB0 + 8'(j));
        run_packet(pl, 16'd2, "straddle");

        // ---------------- heartbeat and end-of-session ----------------
        rdy_mode = 0;
        pl = {};
        for (int j = 0; j < 10; j++) pl.push_back(8'(j + 1));
        run_packet(pl, 16'h0000, "heartbeat");
        run_packet(pl, 16'hFFFF, "end_session");

        // ---------------- header-only packet ----------------
        bif.messageCount = 16'd0;
        send_beat(64'h1122334455667788, 8'd0, 1'b0, 3'd0);
        send_beat(64'h99AABBCCDDEEFF00, 8'd1, 1'b0, 3'd0);
        send_beat(64'h0102030405060708, 8'd2, 1'b1, 3'd4);
        trunc_seen = 0;
        trunc_exp  = 0;
        finish_packet("header_only");

        // ---------------- zero-length block ----------------
        pl = {};
        pl.push_back(8'h00); pl.push_back(8'h00);
        pl.push_back(8'h00); pl.push_back(8'h01); pl.push_back(8'h5A);
        run_packet(pl, 16'd2, "zero_len");

        // ---------------- truncation in body ----------------
        pl = {};
        pl.push_back(8'h00); pl.push_back(8'h0A);
        pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03); pl.push_back(8'h04);
        run_packet(pl, 16'd1, "trunc_body");

        // ---------------- reset at the 3rd body byte ----------------
        mon_en = 1'b0;
        gap_en = 1'b0;
        pl = {};
        pl.push_back(8'h00); pl.push_back(8'h05);
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        pl.push_back(8'h44); pl.push_back(8'h55);
        send_packet(pl, 16'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_third_byte", {24'd0, bif.msgData}, 32'h33);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_valid", {31'd0, bif.msgValid},  32'd0);
        check_eq("rstmid_data",  {24'd0, bif.msgData},   32'd0);
        check_eq("rstmid_last",  {31'd0, bif.msgLast},   32'd0);
        check_eq("rstmid_ready", {31'd0, bif.dataReady}, 32'd1);
        @(posedge clk);
        #1;
        exp_q.delete();
        mon_en = 1'b1;
        pl = {};
        pl.push_back(8'h00); pl.push_back(8'h04);
        pl.push_back(8'hC1); pl.push_back(8'hC2); pl.push_back(8'hC3); pl.push_back(8'hC4);
        run_packet(pl, 16'd1, "after_reset");

        // ---------------- randomized packets ----------------
        gap_en = 1'b1;
        for (int p = 0; p < 60; p++) begin
            rdy_mode = $urandom_range(0, 2);
            rand_packet();
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
